// File: rtl/id_stage_pipelined.sv
// Decode stage of the ARM-subset pipeline: control decode, condition check, bypassed register
// file and the ID/EX pipeline register with freeze/flush handling.
module id_stage_pipelined #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int PC_W     = 32,
    localparam int AW      = ($clog2(NUM_REGS) < 4) ? 4 : $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              in_valid,
    input  logic              status_z,
    input  logic              status_c,
    input  logic              status_n,
    input  logic              status_v,
    input  logic              hazard,
    input  logic              freeze,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic [AW-1:0]     src1,
    output logic [AW-1:0]     src2,
    output logic              two_src,
    output logic              valid_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              b_out,
    output logic              s_out,
    output logic [3:0]        exe_cmd_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic [AW-1:0]     dest_out,
    output logic [PC_W-1:0]   pc_out
);

    localparam logic [AW:0] NumRegsW = (AW+1)'(NUM_REGS);

    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              b;
        logic              s;
        logic [3:0]        exe_cmd;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic              imm;
        logic [11:0]       shift_operand;
        logic [23:0]       signed_imm_24;
        logic [AW-1:0]     dest;
        logic [PC_W-1:0]   pc;
    } idex_t;

    logic [3:0] cond;
    logic [3:0] opcode;
    logic [1:0] mode;
    logic       i_bit;
    logic       s_bit;
    logic       store;

    assign cond   = instruction[31:28];
    assign mode   = instruction[27:26];
    assign i_bit  = instruction[25];
    assign opcode = instruction[24:21];
    assign s_bit  = instruction[20];
    assign store  = (mode == 2'b01) && !s_bit;

    assign src1    = AW'(instruction[19:16]);
    assign src2    = store ? AW'(instruction[15:12]) : AW'(instruction[3:0]);
    assign two_src = !i_bit || store;

    logic       ctl_wb_en;
    logic       ctl_mem_r_en;
    logic       ctl_mem_w_en;
    logic       ctl_b;
    logic       ctl_s;
    logic [3:0] ctl_exe_cmd;

    always_comb begin
        ctl_wb_en    = 1'b0;
        ctl_mem_r_en = 1'b0;
        ctl_mem_w_en = 1'b0;
        ctl_b        = 1'b0;
        ctl_s        = 1'b0;
        ctl_exe_cmd  = 4'b0000;
        case (mode)
            2'b00: begin
                ctl_wb_en = 1'b1;
                ctl_s     = s_bit;
                case (opcode)
                    4'b1101: ctl_exe_cmd = 4'b0001;
                    4'b1111: ctl_exe_cmd = 4'b1001;
                    4'b0100: ctl_exe_cmd = 4'b0010;
                    4'b0101: ctl_exe_cmd = 4'b0011;
                    4'b0010: ctl_exe_cmd = 4'b0100;
                    4'b0110: ctl_exe_cmd = 4'b0101;
                    4'b0000: ctl_exe_cmd = 4'b0110;
                    4'b1100: ctl_exe_cmd = 4'b0111;
                    4'b0001: ctl_exe_cmd = 4'b1000;
                    4'b1010: begin
                        ctl_exe_cmd = 4'b0100;
                        ctl_wb_en   = 1'b0;
                        ctl_s       = 1'b1;
                    end
                    4'b1000: begin
                        ctl_exe_cmd = 4'b0110;
                        ctl_wb_en   = 1'b0;
                        ctl_s       = 1'b1;
                    end
                    default: begin
                        ctl_wb_en = 1'b0;
                        ctl_s     = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                ctl_exe_cmd  = 4'b0010;
                ctl_mem_r_en = s_bit;
                ctl_wb_en    = s_bit;
                ctl_mem_w_en = !s_bit;
            end
            2'b10:   ctl_b = 1'b1;
            default: ;
        endcase
    end

    logic cond_ok;

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'h0: cond_ok = status_z;
            4'h1: cond_ok = !status_z;
            4'h2: cond_ok = status_c;
            4'h3: cond_ok = !status_c;
            4'h4: cond_ok = status_n;
            4'h5: cond_ok = !status_n;
            4'h6: cond_ok = status_v;
            4'h7: cond_ok = !status_v;
            4'h8: cond_ok = status_c && !status_z;
            4'h9: cond_ok = !status_c || status_z;
            4'hA: cond_ok = (status_n == status_v);
            4'hB: cond_ok = (status_n != status_v);
            4'hC: cond_ok = !status_z && (status_n == status_v);
            4'hD: cond_ok = status_z || (status_n != status_v);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    logic kill;
    assign kill = !cond_ok || hazard || !in_valid;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_ok;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign wr_ok = wb_en && ({1'b0, wb_dest} < NumRegsW);

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[wb_dest] = wb_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Same-cycle write-back is forwarded so the decoded operand never sees a stale value.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if ({1'b0, src1} < NumRegsW) rd1 = regs_q[src1];
        if ({1'b0, src2} < NumRegsW) rd2 = regs_q[src2];
        if (wr_ok && (wb_dest == src1)) rd1 = wb_value;
        if (wr_ok && (wb_dest == src2)) rd2 = wb_value;
    end

    idex_t idex_q;
    idex_t idex_d;
    idex_t idex_new;

    always_comb begin
        idex_new               = '0;
        idex_new.valid         = 1'b1;
        idex_new.wb_en         = ctl_wb_en;
        idex_new.mem_r_en      = ctl_mem_r_en;
        idex_new.mem_w_en      = ctl_mem_w_en;
        idex_new.b             = ctl_b;
        idex_new.s             = ctl_s;
        idex_new.exe_cmd       = ctl_exe_cmd;
        idex_new.val_rn        = rd1;
        idex_new.val_rm        = rd2;
        idex_new.imm           = i_bit;
        idex_new.shift_operand = instruction[11:0];
        idex_new.signed_imm_24 = instruction[23:0];
        idex_new.dest          = AW'(instruction[15:12]);
        idex_new.pc            = pc_in;

        idex_d = idex_q;
        // Flush overrides freeze; a squashed slot still loads its data fields.
        if (flush || !freeze) begin
            idex_d = idex_new;
            if (flush || kill) begin
                idex_d.valid    = 1'b0;
                idex_d.wb_en    = 1'b0;
                idex_d.mem_r_en = 1'b0;
                idex_d.mem_w_en = 1'b0;
                idex_d.b        = 1'b0;
                idex_d.s        = 1'b0;
                idex_d.exe_cmd  = 4'b0000;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign valid_out         = idex_q.valid;
    assign wb_en_out         = idex_q.wb_en;
    assign mem_r_en_out      = idex_q.mem_r_en;
    assign mem_w_en_out      = idex_q.mem_w_en;
    assign b_out             = idex_q.b;
    assign s_out             = idex_q.s;
    assign exe_cmd_out       = idex_q.exe_cmd;
    assign val_rn_out        = idex_q.val_rn;
    assign val_rm_out        = idex_q.val_rm;
    assign imm_out           = idex_q.imm;
    assign shift_operand_out = idex_q.shift_operand;
    assign signed_imm_24_out = idex_q.signed_imm_24;
    assign dest_out          = idex_q.dest;
    assign pc_out            = idex_q.pc;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: a decode/condition vector table plus hand sequences
// for register file, bypass, freeze, flush, hazard and asynchronous reset.
module tb_id_stage_pipelined;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int PW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   instruction;
    logic [PW-1:0] pc_in;
    logic          in_valid;
    logic          status_z, status_c, status_n, status_v;
    logic          hazard, freeze, flush;
    logic          wb_en;
    logic [AW-1:0] wb_dest;
    logic [DW-1:0] wb_value;
    logic [AW-1:0] src1, src2;
    logic          two_src;
    logic          valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out;
    logic [3:0]    exe_cmd_out;
    logic [DW-1:0] val_rn_out, val_rm_out;
    logic          imm_out;
    logic [11:0]   shift_operand_out;
    logic [23:0]   signed_imm_24_out;
    logic [AW-1:0] dest_out;
    logic [PW-1:0] pc_out;

    always #5 clk = ~clk;

    id_stage_pipelined #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .PC_W     (PW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .instruction       (instruction),
        .pc_in             (pc_in),
        .in_valid          (in_valid),
        .status_z          (status_z),
        .status_c          (status_c),
        .status_n          (status_n),
        .status_v          (status_v),
        .hazard            (hazard),
        .freeze            (freeze),
        .flush             (flush),
        .wb_en             (wb_en),
        .wb_dest           (wb_dest),
        .wb_value          (wb_value),
        .src1              (src1),
        .src2              (src2),
        .two_src           (two_src),
        .valid_out         (valid_out),
        .wb_en_out         (wb_en_out),
        .mem_r_en_out      (mem_r_en_out),
        .mem_w_en_out      (mem_w_en_out),
        .b_out             (b_out),
        .s_out             (s_out),
        .exe_cmd_out       (exe_cmd_out),
        .val_rn_out        (val_rn_out),
        .val_rm_out        (val_rm_out),
        .imm_out           (imm_out),
        .shift_operand_out (shift_operand_out),
        .signed_imm_24_out (signed_imm_24_out),
        .dest_out          (dest_out),
        .pc_out            (pc_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dp(input logic [3:0] cnd, input logic i, input logic [3:0] opc,
                                       input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                       input logic [11:0] op2);
        return {cnd, 2'b00, i, opc, s, rn, rd, op2};
    endfunction

    function automatic logic [31:0] mem(input logic [3:0] cnd, input logic l, input logic [3:0] rn,
                                        input logic [3:0] rd, input logic [11:0] off);
        return {cnd, 2'b01, 1'b0, 4'b1100, l, rn, rd, off};
    endfunction

    // {valid, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd}
    function automatic logic [9:0] c(input logic v, input logic wb, input logic mr, input logic mw,
                                     input logic b, input logic s, input logic [3:0] cmd);
        return {v, wb, mr, mw, b, s, cmd};
    endfunction

    function automatic logic [8:0] cm(input logic [3:0] s1, input logic [3:0] s2, input logic two);
        return {s1, s2, two};
    endfunction

    function automatic logic [9:0] ctl_act();
        return {valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  nzcv;
        logic        hz;
        logic        iv;
        logic        fl;
        logic [9:0]  ctl;
        logic        s_chk;
        logic [8:0]  comb;
    } vec_t;

    vec_t vq[$];

    task automatic idle();
        instruction = 32'h0;
        pc_in       = '0;
        in_valid    = 1'b0;
        {status_n, status_z, status_c, status_v} = 4'b0000;
        hazard   = 1'b0;
        freeze   = 1'b0;
        flush    = 1'b0;
        wb_en    = 1'b0;
        wb_dest  = '0;
        wb_value = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check(name, 128'(|{valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out,
                           exe_cmd_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
                           signed_imm_24_out, dest_out, pc_out}), 128'h0);
    endtask

    localparam logic [3:0] AL = 4'hE;
    localparam logic [9:0] ADD_OK = 10'b1_1_0_0_0_0_0010;

    initial begin
        logic [9:0] mask;
        logic [31:0] ai;

        vq.push_back('{dp(AL,1,4'hD,0,0,2,12'h0FF), 4'b0000, 0,1,0, c(1,1,0,0,0,0,4'h1), 1, cm(0,4'hF,0)});
        vq.push_back('{dp(AL,0,4'hF,1,0,3,12'h004), 4'b0000, 0,1,0, c(1,1,0,0,0,1,4'h9), 1, cm(0,4,1)});
        vq.push_back('{dp(AL,0,4'h4,0,1,4,12'h005), 4'b0000, 0,1,0, c(1,1,0,0,0,0,4'h2), 1, cm(1,5,1)});
        vq.push_back('{dp(AL,1,4'h5,1,6,7,12'h123), 4'b0000, 0,1,0, c(1,1,0,0,0,1,4'h3), 1, cm(6,3,0)});
        vq.push_back('{dp(AL,0,4'h2,0,8,9,12'h00A), 4'b0000, 0,1,0, c(1,1,0,0,0,0,4'h4), 1, cm(8,4'hA,1)});
        vq.push_back('{dp(AL,0,4'h6,1,2,1,12'h00B), 4'b0000, 0,1,0, c(1,1,0,0,0,1,4'h5), 1, cm(2,4'hB,1)});
        vq.push_back('{dp(AL,0,4'h0,0,3,5,12'h00C), 4'b0000, 0,1,0, c(1,1,0,0,0,0,4'h6), 1, cm(3,4'hC,1)});
        vq.push_back('{dp(AL,1,4'hC,0,4,6,12'h0D0), 4'b0000, 0,1,0, c(1,1,0,0,0,0,4'h7), 1, cm(4,0,0)});
        vq.push_back('{dp(AL,0,4'h1,0,5,7,12'h00E), 4'b0000, 0,1,0, c(1,1,0,0,0,0,4'h8), 1, cm(5,4'hE,1)});
        vq.push_back('{dp(AL,0,4'hA,0,1,0,12'h002), 4'b0000, 0,1,0, c(1,0,0,0,0,1,4'h4), 1, cm(1,2,1)});
        vq.push_back('{dp(AL,1,4'h8,0,2,0,12'h0F0), 4'b0000, 0,1,0, c(1,0,0,0,0,1,4'h6), 1, cm(2,0,0)});
        vq.push_back('{dp(AL,0,4'h3,1,1,2,12'h003), 4'b0000, 0,1,0, c(1,0,0,0,0,0,4'h0), 1, cm(1,3,1)});
        vq.push_back('{mem(AL,1,5,4,12'h010),       4'b0000, 0,1,0, c(1,1,1,0,0,0,4'h2), 0, cm(5,0,1)});
        vq.push_back('{mem(AL,0,5,4,12'h000),       4'b0000, 0,1,0, c(1,0,0,1,0,0,4'h2), 0, cm(5,4,1)});
        vq.push_back('{{AL,3'b101,1'b0,24'h000010}, 4'b0000, 0,1,0, c(1,0,0,0,1,0,4'h0), 1, cm(0,0,0)});
        vq.push_back('{{AL,2'b11,26'h0},            4'b0000, 0,1,0, c(1,0,0,0,0,0,4'h0), 1, cm(0,0,1)});
        // Condition codes on ADD R4,R1,R5; flags are {N,Z,C,V}.
        vq.push_back('{dp(4'h0,0,4'h4,0,1,4,12'h005), 4'b0000, 0,1,0, 10'h0,  1, cm(1,5,1)});
        vq.push_back('{dp(4'h0,0,4'h4,0,1,4,12'h005), 4'b0100, 0,1,0, ADD_OK, 1, cm(1,5,1)});
        vq.push_back('{dp(4'h1,0,4'h4,0,1,4,12'h005), 4'b0100, 0,1,0, 10'h0,  1, cm(1,5,1)});
        vq.push_back('{dp(4'h2,0,4'h4,0,1,4,12'h005), 4'b0010, 0,1,0, ADD_OK, 1, cm(1,5,1)});
        vq.push_back('{dp(4'h3,0,4'h4,0,1,4,12'h005), 4'b0010, 0,1,0, 10'h0,  1, cm(1,5,1)});
        vq.push_back('{dp(4'h4,0,4'h4,0,1,4,12'h005), 4'b1000, 0,1,0, ADD_OK, 1, cm(1,5,1)});
        vq.push_back('{dp(4'h5,0,4'h4,0,1,4,12'h005), 4'b1000, 0,1,0, 10'h0,  1, cm(1,5,1)});
        vq.push_back('{dp(4'h6,0,4'h4,0,1,4,12'h005), 4'b0000, 0,1,0, 10'h0,  1, cm(1,5,1)});
        vq.push_back('{dp(4'h7,0,4'h4,0,1,4,12'h005), 4'b0001, 0,1,0, 10'h0,  1, cm(1,5,1)});
        vq.push_back('{dp(4'h8,0,4'h4,0,1,4,12'h005), 4'b0010, 0,1,0, ADD_OK, 1, cm(1,5,1)});
        vq.push_back('{dp(4'h9,0,4'h4,0,1,4,12'h005), 4'b0010, 0,1,0, 10'h0,  1, cm(1,5,1)});
        vq.push_back('{dp(4'hA,0,4'h4,0,1,4,12'h005), 4'b1001, 0,1,0, ADD_OK, 1, cm(1,5,1)});
        vq.push_back('{dp(4'hB,0,4'h4,0,1,4,12'h005), 4'b1000, 0,1,0, ADD_OK, 1, cm(1,5,1)});
        vq.push_back('{dp(4'hC,0,4'h4,0,1,4,12'h005), 4'b0001, 0,1,0, 10'h0,  1, cm(1,5,1)});
        vq.push_back('{dp(4'hD,0,4'h4,0,1,4,12'h005), 4'b1000, 0,1,0, ADD_OK, 1, cm(1,5,1)});
        vq.push_back('{dp(4'hF,0,4'h4,0,1,4,12'h005), 4'b1111, 0,1,0, 10'h0,  1, cm(1,5,1)});
        vq.push_back('{dp(AL,0,4'h4,0,1,4,12'h005),   4'b0000, 1,1,0, 10'h0,  1, cm(1,5,1)});
        vq.push_back('{dp(AL,0,4'h4,0,1,4,12'h005),   4'b0000, 0,0,0, 10'h0,  1, cm(1,5,1)});
        vq.push_back('{dp(AL,0,4'h4,0,1,4,12'h005),   4'b0000, 0,1,1, 10'h0,  1, cm(1,5,1)});

        // Reset held with random inputs.
        rst = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            instruction = $urandom;
            pc_in       = $urandom;
            {in_valid, status_n, status_z, status_c, status_v} = 5'($urandom);
            {hazard, freeze, flush, wb_en} = 4'($urandom);
            wb_dest  = 4'($urandom);
            wb_value = $urandom;
            #1;
            check_all_zero($sformatf("reset_hold%0d", k));
        end
        @(negedge clk);
        idle();
        rst = 1'b1;

        for (int r = 0; r < NR; r++) begin
            @(negedge clk);
            instruction = dp(AL, 0, 4'h0, 0, 4'(r), 4'h0, {8'h0, 4'(r)});
            in_valid    = 1'b1;
            step();
            check($sformatf("reset_reg%0d", r), {val_rn_out, val_rm_out}, 64'h0);
        end

        // Write R3, then read it back through ADD R1,R3,R2.
        @(negedge clk);
        idle();
        wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'hDEADBEEF;
        @(negedge clk);
        wb_en = 1'b0;
        ai = dp(AL, 0, 4'h4, 0, 4'd3, 4'd1, 12'h002);
        instruction = ai; in_valid = 1'b1; pc_in = 32'h100;
        step();
        check("add_ctl", ctl_act(), ADD_OK);
        check("add_ops", {val_rn_out, val_rm_out}, {32'hDEADBEEF, 32'h0});
        check("add_dest_pc", {dest_out, pc_out}, {4'd1, 32'h100});

        // Same-cycle bypass on Rm, then on Rn with R2 now persisted.
        @(negedge clk);
        wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h55;
        step();
        check("bypass_rm", {val_rn_out, val_rm_out}, {32'hDEADBEEF, 32'h55});
        @(negedge clk);
        wb_dest = 4'd3; wb_value = 32'h12345678;
        step();
        check("bypass_rn", {val_rn_out, val_rm_out}, {32'h12345678, 32'h55});

        // Freeze for three cycles with changing inputs and a write to R3 underneath.
        @(negedge clk);
        wb_en = 1'b0;
        instruction = dp(AL, 0, 4'h4, 1, 4'd3, 4'd6, 12'h002); pc_in = 32'h200;
        step();
        check("pre_freeze_ctl", ctl_act(), 10'b1_1_0_0_0_1_0010);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            freeze = 1'b1;
            instruction = dp(AL, 1, 4'hD, 0, 4'(k), 4'(k + 8), 12'h0F0 + 12'(k));
            pc_in = 32'h300 + 32'(k);
            wb_en = (k == 1); wb_dest = 4'd3; wb_value = 32'hAAAA0000;
            step();
            check($sformatf("freeze%0d_ctl", k), ctl_act(), 10'b1_1_0_0_0_1_0010);
            check($sformatf("freeze%0d_data", k),
                  {val_rn_out, val_rm_out, dest_out, pc_out, imm_out, shift_operand_out},
                  {32'h12345678, 32'h55, 4'd6, 32'h200, 1'b0, 12'h002});
        end
        @(negedge clk);
        freeze = 1'b0; wb_en = 1'b0;
        instruction = dp(AL, 0, 4'h4, 1, 4'd3, 4'd6, 12'h002); pc_in = 32'h204;
        step();
        check("post_freeze", {valid_out, val_rn_out, pc_out}, {1'b1, 32'hAAAA0000, 32'h204});

        // Flush together with freeze squashes the slot.
        @(negedge clk);
        freeze = 1'b1; flush = 1'b1; pc_in = 32'h208;
        step();
        check("flush_freeze_ctl", ctl_act(), 10'h0);
        check("flush_freeze_pc", pc_out, 32'h208);

        // Hazard bubble still carries the data fields.
        @(negedge clk);
        freeze = 1'b0; flush = 1'b0; hazard = 1'b1; pc_in = 32'h20C;
        step();
        check("hazard_ctl", ctl_act(), 10'h0);
        check("hazard_data", {val_rn_out, pc_out}, {32'hAAAA0000, 32'h20C});

        // Decode / condition table.
        foreach (vq[i]) begin
            @(negedge clk);
            idle();
            instruction = vq[i].instr;
            {status_n, status_z, status_c, status_v} = vq[i].nzcv;
            hazard   = vq[i].hz;
            in_valid = vq[i].iv;
            flush    = vq[i].fl;
            pc_in    = 32'h1000 + 32'(4 * i);
            #1;
            check($sformatf("vec%0d_comb", i), {src1, src2, two_src}, vq[i].comb);
            step();
            mask = vq[i].s_chk ? 10'h3FF : 10'h3EF;
            check($sformatf("vec%0d_ctl", i), ctl_act() & mask, vq[i].ctl & mask);
            check($sformatf("vec%0d_fields", i),
                  {imm_out, shift_operand_out, signed_imm_24_out, dest_out, pc_out},
                  {vq[i].instr[25], vq[i].instr[11:0], vq[i].instr[23:0], vq[i].instr[15:12],
                   32'h1000 + 32'(4 * i)});
        end

        // Asynchronous reset mid-operation clears slot and register file at once.
        @(negedge clk);
        idle();
        instruction = dp(AL, 0, 4'h4, 0, 4'd3, 4'd1, 12'h002); in_valid = 1'b1; pc_in = 32'h400;
        step();
        check("pre_reset", {valid_out, val_rn_out, val_rm_out}, {1'b1, 32'hAAAA0000, 32'h55});
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        step();
        check("post_reset_regs", {valid_out, val_rn_out, val_rm_out}, {1'b1, 64'h0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
